// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and pairs each
// returned instruction with its PC, handling stall, redirect and fetch faults.
module inst_fetch #(
  parameter int INST_ADDR_WIDTH = 16,
  parameter int INST_DATA_WIDTH = 16,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  output logic [INST_ADDR_WIDTH-1:0] mem_addr,
  input  logic [INST_DATA_WIDTH-1:0] mem_data,
  input  logic                       mem_exc,
  output logic [INST_DATA_WIDTH-1:0] inst,
  output logic [INST_ADDR_WIDTH-1:0] inst_pc,
  output logic                       inst_valid,
  output logic                       fault,
  output logic [1:0]                 fault_cause,
  output logic [INST_ADDR_WIDTH-1:0] fault_pc,
  output logic                       state_dbg
);

  // Handshake: inst_valid qualifies inst/inst_pc in the current cycle; stall is the
  // decode stage's not-ready, and while it is high the same instruction is re-presented
  // (valid stays up) until stall is low at a rising edge.

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_RANGE = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;
  localparam logic [INST_ADDR_WIDTH-1:0] STEP = INST_ADDR_WIDTH'(2);

  state_t                     state, state_nxt;
  logic [INST_ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [INST_ADDR_WIDTH-1:0] pend_pc, pend_pc_nxt;
  logic                       pend_valid, pend_valid_nxt;
  logic                       fault_nxt;
  logic [1:0]                 fault_cause_nxt;
  logic [INST_ADDR_WIDTH-1:0] fault_pc_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      pend_pc     <= '0;
      pend_valid  <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      fault_pc    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_pc     <= pend_pc_nxt;
      pend_valid  <= pend_valid_nxt;
      fault       <= fault_nxt;
      fault_cause <= fault_cause_nxt;
      fault_pc    <= fault_pc_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pend_pc_nxt     = pend_pc;
    pend_valid_nxt  = pend_valid;
    fault_nxt       = fault;
    fault_cause_nxt = fault_cause;
    fault_pc_nxt    = fault_pc;
    mem_addr        = pc;

    if (redirect) begin
      mem_addr = redirect_pc;
      if (redirect_pc[0]) begin
        state_nxt       = FAULT;
        fault_nxt       = 1'b1;
        fault_cause_nxt = CAUSE_ALIGN;
        fault_pc_nxt    = redirect_pc;
        pend_valid_nxt  = 1'b0;
      end else begin
        // The pending fetch is wrong-path, so any exception it carries is dropped.
        state_nxt      = RUN;
        pend_pc_nxt    = redirect_pc;
        pend_valid_nxt = 1'b1;
        pc_nxt         = redirect_pc + STEP;
      end
    end else if (state == RUN) begin
      if (stall) mem_addr = pend_pc;
      if (pend_valid && mem_exc) begin
        state_nxt       = FAULT;
        fault_nxt       = 1'b1;
        fault_cause_nxt = CAUSE_RANGE;
        fault_pc_nxt    = pend_pc;
        pend_valid_nxt  = 1'b0;
      end else if (!stall) begin
        pend_pc_nxt    = pc;
        pend_valid_nxt = 1'b1;
        pc_nxt         = pc + STEP;
      end
    end
  end

  assign inst       = mem_data;
  assign inst_pc    = pend_pc;
  assign inst_valid = pend_valid && !mem_exc && (state == RUN);
  assign state_dbg  = (state == FAULT);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: registered memory image, random stall/redirect traffic, a
// flow-level reference model and an expected-instruction queue drained by a monitor.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_exc;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [15:0] fault_pc;
  logic        state_dbg;

  int total = 0;
  int bad = 0;

  inst_fetch #(.INST_ADDR_WIDTH(16), .INST_DATA_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_exc(mem_exc), .inst(inst),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .fault(fault), .fault_cause(fault_cause),
    .fault_pc(fault_pc), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // instruction memory: 4096 bytes, range flag for any address >= 4095
  logic [15:0] img [0:32767];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_data <= '0;
      mem_exc  <= 1'b0;
    end else begin
      mem_data <= img[mem_addr[15:1]];
      mem_exc  <= (mem_addr >= 16'd4095);
    end
  end

  // reference model: where the program flow is, and what the fault record says
  logic [15:0] m_next;     // next sequential fetch address
  logic [15:0] m_last;     // address most recently handed to memory for decode
  logic        m_live;     // that fetch is destined for decode
  logic        m_halted;   // stopped on a fault, waiting for a redirect
  logic        m_fault;
  logic [1:0]  m_cause;
  logic [15:0] m_fpc;

  logic [15:0] exp_addr, exp_fpc;
  logic        exp_valid, exp_fault, exp_state;
  logic [1:0]  exp_cause;
  logic [31:0] exp_q[$];
  logic        pushed_now;
  logic        mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_next = 16'h0000; m_last = 16'h0000; m_live = 1'b0; m_halted = 1'b0;
    m_fault = 1'b0; m_cause = 2'b00; m_fpc = 16'h0000;
    exp_q.delete();
  endtask

  // drive one cycle's inputs, record this cycle's expectations, advance the flow model
  task automatic set_cycle(input logic s, input logic r, input logic [15:0] rp);
    stall = s; redirect = r; redirect_pc = rp;
    if (r) exp_addr = rp;
    else if (!m_halted && s) exp_addr = m_last;
    else exp_addr = m_next;
    exp_valid = m_live && !m_halted && (m_last < 16'd4095);
    exp_fault = m_fault; exp_cause = m_cause; exp_fpc = m_fpc; exp_state = m_halted;

    if (r && rp[0]) begin
      m_halted = 1'b1; m_fault = 1'b1; m_cause = 2'b10; m_fpc = rp; m_live = 1'b0;
    end else if (r) begin
      m_halted = 1'b0; m_last = rp; m_live = 1'b1; m_next = rp + 16'd2;
    end else if (!m_halted) begin
      if (m_live && m_last >= 16'd4095) begin
        m_halted = 1'b1; m_fault = 1'b1; m_cause = 2'b01; m_fpc = m_last; m_live = 1'b0;
      end else if (!s) begin
        m_last = m_next; m_live = 1'b1; m_next = m_next + 16'd2;
      end
    end
    pushed_now = m_live && !m_halted && (m_last < 16'd4095);
    if (pushed_now) exp_q.push_back({m_last, img[m_last[15:1]]});
  endtask

  task automatic cycle(input logic s, input logic r, input logic [15:0] rp);
    set_cycle(s, r, rp);
    @(posedge clk); #1;
  endtask

  task automatic flush();
    set_cycle(1'b0, 1'b0, 16'h0000);
    @(negedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'(pushed_now));
    mon_en = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_pc", inst_pc, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_fault", fault, 1'b0);
    chk("rst_fault_cause", fault_cause, 2'b00);
    chk("rst_fault_pc", fault_pc, 16'h0000);
    chk("rst_state", state_dbg, 1'b0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] e;
      chk("inst_valid", inst_valid, exp_valid);
      chk("mem_addr", mem_addr, exp_addr);
      chk("fault", fault, exp_fault);
      chk("fault_cause", fault_cause, exp_cause);
      chk("fault_pc", fault_pc, exp_fpc);
      chk("state", state_dbg, exp_state);
      if (inst_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_inst: got pc=%h inst=%h want none", inst_pc, inst);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e[31:16]);
          chk("inst", inst, e[15:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic s, r;
    logic [15:0] rp;
    for (int i = 0; i < 32768; i++) img[i] = 16'($urandom);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b1;
    mon_en = 1'b1;

    // straight-line fetch, then a 3-cycle stall while 0x0006 is presented
    repeat (4) cycle(1'b0, 1'b0, 16'h0);
    repeat (3) cycle(1'b1, 1'b0, 16'h0);
    repeat (3) cycle(1'b0, 1'b0, 16'h0);

    // misaligned redirect, idle in fault with stall noise, then aligned recovery
    cycle(1'b0, 1'b1, 16'h0101);
    repeat (4) cycle(1'($urandom_range(0, 1)), 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'h0200);
    repeat (4) cycle(1'b0, 1'b0, 16'h0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      s  = ($urandom_range(0, 99) < 25);
      r  = ($urandom_range(0, 99) < 8);
      rp = 16'($urandom_range(0, 2100) * 2);
      if ($urandom_range(0, 9) == 0) rp[0] = 1'b1;
      cycle(s, r, rp);
    end

    // run off the end of memory: 0x0FFE is valid, 0x1000 faults
    cycle(1'b0, 1'b1, 16'h0FF0);
    repeat (14) cycle(1'b0, 1'b0, 16'h0);
    flush();

    // asynchronous reset while in FAULT
    #2;
    rst = 1'b0;
    #1;
    chk_reset();
    @(posedge clk); #1;
    model_reset();
    rst = 1'b1;
    mon_en = 1'b1;

    // restart from RESET_PC; redirect to 0x0100 while 0x0004 is presented
    repeat (3) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'h0100);
    repeat (3) cycle(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 100; i++)
      cycle(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 6),
            16'($urandom_range(0, 2047) * 2));
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
